decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter REG_COUNT, default 8, number of general-purpose registers; REQ-002 Parameter DATA_W, default 32, register and datapath width.
REQ-003 Ports: clk  in  1  single clock; all flops rising-edge.
REQ-004 reset  in  1  asynchronous, active-low; the same reset net that drives fetch_stage.
REQ-005 instruction_r  in  16  fetched word: [15:11] opcode, [10:8] rd, [7:5] rs, [4:2] rt.
REQ-006 pc_plus_one_r  in  32  PC+1 paired with instruction_r.
REQ-007 immediate_value  in  16  second word of a two-word instruction.
REQ-008 flush  in  1  branch taken; squash the current decode contents.
REQ-009 wb_en / wb_addr / wb_data  in  1/3/32  register-file write port from write-back.
REQ-010 stall_fetch  out  1  freezes the fetch instruction register.
REQ-011 id_valid, id_opcode[4:0], id_rd[2:0], id_rs_data[31:0], id_rt_data[31:0], id_imm[31:0], id_pc_plus_one[31:0], id_mem_read  out  registered ID/EX bundle.

Function
REQ-012 A two-word opcode has opcode[4:3]==2'b11; a load opcode is LDD=5'b11001.
REQ-013 FSM states: NORMAL and IMM_WAIT; reset state is NORMAL.
REQ-014 NORMAL, one-word opcode: ID/EX loads a fully decoded instruction on the next edge (1-cycle latency), and id_valid=1.
REQ-015 NORMAL, two-word opcode: the block latches opcode, rd, rs and rt, moves to IMM_WAIT and emits a bubble (id_valid=0).
REQ-016 IMM_WAIT: id_imm = sign-extended immediate_value, the held fields are issued with id_valid=1, and the FSM returns to NORMAL.
REQ-017 Load-use hazard: id_valid&id_mem_read is high and id_rd equals the rs or rt of the current one-word instruction. The block asserts stall_fetch combinationally, inserts a bubble and holds its state; the stall lasts exactly 1 cycle.
REQ-018 stall_fetch shall never be asserted in IMM_WAIT, because the immediate word is consumed there.
REQ-019 flush takes priority over a hazard and over IMM_WAIT: the next edge gives id_valid=0, FSM=NORMAL and discards the held fields.
REQ-020 Register file: 2 combinational reads (rs, rt) and 1 synchronous write on wb_en; register 0 is writable (no hard-wired zero).
REQ-021 A bubble forces id_valid=0 and id_mem_read=0; the other ID/EX fields are don't-care.
REQ-022 For a one-word instruction, id_imm = zero-extended instruction_r[4:0].

Reset
REQ-023 Reset assertion asynchronously clears all ID/EX outputs to 0 and the FSM to NORMAL; stall_fetch reads 0 while reset is asserted.
REQ-024 Register-file contents reset to 0.
REQ-025 Reset asserted mid-IMM_WAIT abandons the pending instruction; no partial issue follows deassertion.

Configuration
REQ-026 With DECODE_WB_BYPASS_EN defined, a read whose address equals wb_addr while wb_en=1 returns wb_data in the same cycle (write-first).
REQ-027 Without DECODE_WB_BYPASS_EN, that read returns the old register value and the new value is visible from the next cycle.

Structure
REQ-028 Package decode_pkg holds: opcode field positions, an opcode_t enum including LDD, the state_t enum (NORMAL, IMM_WAIT), and an is_two_word() function.
REQ-029 Sub-module register_file (REG_COUNT x DATA_W, 2R1W) is instantiated once; the FSM, hazard logic and ID/EX register live in decode_stage.

Verification
REQ-030 One-word: instruction_r=16'h0A4C with R2=5 and R3=7 -> next cycle id_opcode=5'h01, id_rd=2, id_rs_data=5, id_rt_data=7, id_valid=1.
REQ-031 Two-word: opcode 5'b11000, then immediate_value=16'hFFFE -> cycle 1 id_valid=0; cycle 2 id_valid=1, id_imm=32'hFFFFFFFE.
REQ-032 Load-use: LDD with rd=3, followed by an instruction with rs=3 -> stall_fetch=1 for 1 cycle, one bubble, then normal issue.
REQ-033 flush=1 during IMM_WAIT -> next cycle id_valid=0, FSM=NORMAL, no issue of the held instruction.
REQ-034 wb_en=1, wb_addr=4, wb_data=32'h1234 while the current instruction reads rs=4 -> id_rs_data=32'h1234 with DECODE_WB_BYPASS_EN defined, the old value without it.
REQ-035 Reset asserted while in IMM_WAIT -> all outputs 0 immediately; after release, the first one-word instruction issues normally.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - instruction field layout, opcodes and decode state types
package decode_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 5;
    localparam int RT_MSB  = 4;
    localparam int RT_LSB  = 2;

    typedef enum logic [4:0] {
        NOP = 5'b00000,
        ADD = 5'b00001,
        SUB = 5'b00010,
        LDM = 5'b11000,
        LDD = 5'b11001,
        STD = 5'b11010
    } opcode_t;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        IMM_WAIT = 1'b1
    } state_t;

    function automatic logic is_two_word(input logic [4:0] opcode);
        return opcode[4:3] == 2'b11;
    endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2R1W register file; DECODE_WB_BYPASS_EN selects write-first reads
module register_file #(
    parameter int REG_COUNT = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [2:0]        raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [REG_COUNT];

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    // Same-cycle write-back is forwarded so decode never sees a stale operand.
    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
`else
    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];
`endif

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: two-word FSM, load-use stall, flush, ID/EX register
module decode_stage
    import decode_pkg::*;
#(
    parameter int REG_COUNT = 8,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instruction_r,
    input  logic [31:0]       pc_plus_one_r,
    input  logic [15:0]       immediate_value,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_fetch,
    output logic              id_valid,
    output logic [4:0]        id_opcode,
    output logic [2:0]        id_rd,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm,
    output logic [31:0]       id_pc_plus_one,
    output logic              id_mem_read
);

    localparam logic [0:0] S_NORMAL   = NORMAL;
    localparam logic [0:0] S_IMM_WAIT = IMM_WAIT;

    logic [0:0] state_q, state_d;
    logic [4:0] hold_opc_q, hold_opc_d;
    logic [2:0] hold_rd_q, hold_rd_d;
    logic [2:0] hold_rs_q, hold_rs_d;
    logic [2:0] hold_rt_q, hold_rt_d;

    logic              id_valid_q, id_valid_d;
    logic [4:0]        id_opcode_q, id_opcode_d;
    logic [2:0]        id_rd_q, id_rd_d;
    logic [DATA_W-1:0] id_rs_data_q, id_rs_data_d;
    logic [DATA_W-1:0] id_rt_data_q, id_rt_data_d;
    logic [DATA_W-1:0] id_imm_q, id_imm_d;
    logic [31:0]       id_pc_q, id_pc_d;
    logic              id_mem_read_q, id_mem_read_d;

    logic [4:0]        opc_w;
    logic [2:0]        rd_w, rs_w, rt_w;
    logic              in_imm_w, two_word_w, hazard_w;
    logic [2:0]        rs_addr_w, rt_addr_w;
    logic [DATA_W-1:0] rs_rdata_w, rt_rdata_w;

    assign opc_w = instruction_r[OPC_MSB:OPC_LSB];
    assign rd_w  = instruction_r[RD_MSB:RD_LSB];
    assign rs_w  = instruction_r[RS_MSB:RS_LSB];
    assign rt_w  = instruction_r[RT_MSB:RT_LSB];

    assign in_imm_w   = (state_q == S_IMM_WAIT);
    assign two_word_w = is_two_word(opc_w);

    // The held instruction reads its operands while its immediate word arrives.
    assign rs_addr_w = in_imm_w ? hold_rs_q : rs_w;
    assign rt_addr_w = in_imm_w ? hold_rt_q : rt_w;

    register_file #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W)
    ) u_register_file (
        .clk       (clk),
        .rst_ni    (reset),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data),
        .raddr_a_i (rs_addr_w),
        .rdata_a_o (rs_rdata_w),
        .raddr_b_i (rt_addr_w),
        .rdata_b_o (rt_rdata_w)
    );

    // Only a one-word instruction in NORMAL can hit a load-use hazard.
    assign hazard_w = !in_imm_w && !two_word_w && id_valid_q && id_mem_read_q
                      && ((id_rd_q == rs_w) || (id_rd_q == rt_w));

    assign stall_fetch = hazard_w && !flush && reset;

    always_comb begin
        state_d    = state_q;
        hold_opc_d = hold_opc_q;
        hold_rd_d  = hold_rd_q;
        hold_rs_d  = hold_rs_q;
        hold_rt_d  = hold_rt_q;

        id_opcode_d  = in_imm_w ? hold_opc_q : opc_w;
        id_rd_d      = in_imm_w ? hold_rd_q : rd_w;
        id_rs_data_d = rs_rdata_w;
        id_rt_data_d = rt_rdata_w;
        id_imm_d     = in_imm_w ? {{(DATA_W-16){immediate_value[15]}}, immediate_value}
                                : {{(DATA_W-5){1'b0}}, instruction_r[4:0]};
        id_pc_d      = pc_plus_one_r;
        id_valid_d   = 1'b0;

        if (flush) begin
            state_d = S_NORMAL;
        end else if (in_imm_w) begin
            id_valid_d = 1'b1;
            state_d    = S_NORMAL;
        end else if (two_word_w) begin
            hold_opc_d = opc_w;
            hold_rd_d  = rd_w;
            hold_rs_d  = rs_w;
            hold_rt_d  = rt_w;
            state_d    = S_IMM_WAIT;
        end else if (!hazard_w) begin
            id_valid_d = 1'b1;
        end

        id_mem_read_d = id_valid_d && (id_opcode_d == LDD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_NORMAL;
            hold_opc_q    <= '0;
            hold_rd_q     <= '0;
            hold_rs_q     <= '0;
            hold_rt_q     <= '0;
            id_valid_q    <= 1'b0;
            id_opcode_q   <= '0;
            id_rd_q       <= '0;
            id_rs_data_q  <= '0;
            id_rt_data_q  <= '0;
            id_imm_q      <= '0;
            id_pc_q       <= '0;
            id_mem_read_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_opc_q    <= hold_opc_d;
            hold_rd_q     <= hold_rd_d;
            hold_rs_q     <= hold_rs_d;
            hold_rt_q     <= hold_rt_d;
            id_valid_q    <= id_valid_d;
            id_opcode_q   <= id_opcode_d;
            id_rd_q       <= id_rd_d;
            id_rs_data_q  <= id_rs_data_d;
            id_rt_data_q  <= id_rt_data_d;
            id_imm_q      <= id_imm_d;
            id_pc_q       <= id_pc_d;
            id_mem_read_q <= id_mem_read_d;
        end
    end

    assign id_valid       = id_valid_q;
    assign id_opcode      = id_opcode_q;
    assign id_rd          = id_rd_q;
    assign id_rs_data     = id_rs_data_q;
    assign id_rt_data     = id_rt_data_q;
    assign id_imm         = id_imm_q;
    assign id_pc_plus_one = id_pc_q;
    assign id_mem_read    = id_mem_read_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed and randomized bench for decode_stage against a behavioural model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction_r = '0;
    logic [31:0] pc_plus_one_r = '0;
    logic [15:0] immediate_value = '0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall_fetch;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [2:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [31:0] id_pc_plus_one;
    logic        id_mem_read;

    always #5 clk = ~clk;

    decode_stage #(.REG_COUNT(8), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction_r   (instruction_r),
        .pc_plus_one_r   (pc_plus_one_r),
        .immediate_value (immediate_value),
        .flush           (flush),
        .wb_en           (wb_en),
        .wb_addr         (wb_addr),
        .wb_data         (wb_data),
        .stall_fetch     (stall_fetch),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rd           (id_rd),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_pc_plus_one  (id_pc_plus_one),
        .id_mem_read     (id_mem_read)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_regs [8];
    bit          m_pend;
    logic [15:0] m_hold;
    bit          m_valid, m_mem_read;
    logic [4:0]  m_op;
    logic [2:0]  m_rd;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_pc;
    logic        obs_stall;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_pend = 0; m_hold = '0; m_valid = 0; m_mem_read = 0;
        m_op = '0; m_rd = '0; m_rs_data = '0; m_rt_data = '0; m_imm = '0; m_pc = '0;
    endtask

    function automatic bit two_word(input logic [15:0] w);
        return (w >> 14) == 16'd3;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [2:0] a, input logic we,
                                           input logic [2:0] wa, input logic [31:0] wd);
`ifdef DECODE_WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return m_regs[a];
    endfunction

    task automatic step(input logic [15:0] ins, input logic [15:0] imm, input logic fl,
                        input logic we, input logic [2:0] wa, input logic [31:0] wd);
        logic [31:0] pc;
        logic [15:0] word;
        logic [2:0]  irs, irt;
        bit          load_use;
        pc = $urandom;
        instruction_r = ins; pc_plus_one_r = pc; immediate_value = imm;
        flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        word = m_pend ? m_hold : ins;
        irs = 3'((ins >> 5) & 16'h7);
        irt = 3'((ins >> 2) & 16'h7);
        load_use = !m_pend && !two_word(ins) && m_valid && m_mem_read
                   && (m_rd == irs || m_rd == irt);
        #2;
        obs_stall = stall_fetch;
        check("stall_fetch", 64'(stall_fetch), 64'(load_use && !fl));
        @(posedge clk);
        if (fl) begin
            m_pend = 0; m_valid = 0; m_mem_read = 0;
        end else if (!m_pend && two_word(ins)) begin
            m_pend = 1; m_hold = ins; m_valid = 0; m_mem_read = 0;
        end else if (load_use) begin
            m_valid = 0; m_mem_read = 0;
        end else begin
            m_valid    = 1;
            m_op       = 5'(word >> 11);
            m_rd       = 3'((word >> 8) & 16'h7);
            m_rs_data  = rd_reg(3'((word >> 5) & 16'h7), we, wa, wd);
            m_rt_data  = rd_reg(3'((word >> 2) & 16'h7), we, wa, wd);
            m_imm      = m_pend ? 32'($signed(imm)) : 32'(ins % 32);
            m_mem_read = (m_op == 5'b11001);
            m_pc       = pc;
            m_pend     = 0;
        end
        if (we) m_regs[wa] = wd;
        #1;
        check("id_valid", 64'(id_valid), 64'(m_valid));
        check("id_mem_read", 64'(id_mem_read), 64'(m_mem_read));
        if (m_valid) begin
            check("id_opcode", 64'(id_opcode), 64'(m_op));
            check("id_rd", 64'(id_rd), 64'(m_rd));
            check("id_rs_data", 64'(id_rs_data), 64'(m_rs_data));
            check("id_rt_data", 64'(id_rt_data), 64'(m_rt_data));
            check("id_imm", 64'(id_imm), 64'(m_imm));
            check("id_pc_plus_one", 64'(id_pc_plus_one), 64'(m_pc));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(id_valid), 64'd0);
        check({tag, "_opcode"}, 64'(id_opcode), 64'd0);
        check({tag, "_rd"}, 64'(id_rd), 64'd0);
        check({tag, "_rs_data"}, 64'(id_rs_data), 64'd0);
        check({tag, "_rt_data"}, 64'(id_rt_data), 64'd0);
        check({tag, "_imm"}, 64'(id_imm), 64'd0);
        check({tag, "_pc"}, 64'(id_pc_plus_one), 64'd0);
        check({tag, "_mem_read"}, 64'(id_mem_read), 64'd0);
        check({tag, "_stall"}, 64'(stall_fetch), 64'd0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0] op;
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)      op = 5'b11001;
        else if (r < 5) op = {2'b11, 3'($urandom_range(0, 7))};
        else            op = 5'($urandom);
        return {op, 11'($urandom)};
    endfunction

    localparam logic [15:0] I_ONE  = 16'h0A4C;
    localparam logic [15:0] I_LDM  = {5'b11000, 3'd1, 3'd2, 3'd3, 2'b00};
    localparam logic [15:0] I_LDD3 = {5'b11001, 3'd3, 3'd0, 3'd0, 2'b00};
    localparam logic [15:0] I_USE3 = 16'h0960;
    localparam logic [15:0] I_RS4  = 16'h1580;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;

        // one-word issue with R2=5, R3=7
        step(16'h0000, 16'h0, 1'b0, 1'b1, 3'd2, 32'd5);
        step(16'h0000, 16'h0, 1'b0, 1'b1, 3'd3, 32'd7);
        step(I_ONE, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("one_opcode", 64'(id_opcode), 64'h01);
        check("one_rd", 64'(id_rd), 64'd2);
        check("one_rs", 64'(id_rs_data), 64'd5);
        check("one_rt", 64'(id_rt_data), 64'd7);
        check("one_valid", 64'(id_valid), 64'd1);

        // two-word with negative immediate
        step(I_LDM, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("two_bubble", 64'(id_valid), 64'd0);
        step(16'h0000, 16'hFFFE, 1'b0, 1'b0, 3'd0, 32'd0);
        check("two_valid", 64'(id_valid), 64'd1);
        check("two_imm", 64'(id_imm), 64'hFFFF_FFFE);
        check("two_opcode", 64'(id_opcode), 64'h18);

        // load-use stall
        step(I_LDD3, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        step(16'h0000, 16'h0010, 1'b0, 1'b0, 3'd0, 32'd0);
        check("ldd_mem_read", 64'(id_mem_read), 64'd1);
        step(I_USE3, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("lu_stall", 64'(obs_stall), 64'd1);
        check("lu_bubble", 64'(id_valid), 64'd0);
        step(I_USE3, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("lu_stall_end", 64'(obs_stall), 64'd0);
        check("lu_issue", 64'(id_valid), 64'd1);

        // flush during IMM_WAIT
        step(I_LDM, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        step(16'h0000, 16'h1234, 1'b1, 1'b0, 3'd0, 32'd0);
        check("flush_bubble", 64'(id_valid), 64'd0);
        step(16'h0000, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("flush_next_valid", 64'(id_valid), 64'd1);
        check("flush_next_opcode", 64'(id_opcode), 64'd0);

        // same-cycle write-back vs read
        step(16'h0000, 16'h0, 1'b0, 1'b1, 3'd4, 32'hAAAA);
        step(I_RS4, 16'h0, 1'b0, 1'b1, 3'd4, 32'h1234);
`ifdef DECODE_WB_BYPASS_EN
        check("wb_same_cycle", 64'(id_rs_data), 64'h1234);
`else
        check("wb_same_cycle", 64'(id_rs_data), 64'hAAAA);
`endif
        step(I_RS4, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("wb_next_cycle", 64'(id_rs_data), 64'h1234);

        // reset while in IMM_WAIT
        step(I_LDM, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        reset = 1'b0;
        #1;
        check_zero("imm_reset");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(I_ONE, 16'h0, 1'b0, 1'b0, 3'd0, 32'd0);
        check("post_reset_valid", 64'(id_valid), 64'd1);
        check("post_reset_opcode", 64'(id_opcode), 64'h01);
        check("post_reset_rs", 64'(id_rs_data), 64'd0);

        for (int n = 0; n < 1500; n++) begin
            step(rand_instr(), 16'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
